// File: rtl/uart_rx_fifo.sv
// UART receiver: synchronised and majority-filtered RX line, frame FSM with parity and stop checks,
// sticky error flags and a show-ahead receive FIFO.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | line idle; counting low time to reach the middle of the start bit
// S_START | mid-start bit; confirm the line is still low, then wait for data bit 0
// S_DATA  | shifting in data bits, LSB first
// S_PARITY| sampling the parity bit
// S_STOP  | sampling stop bit(s); push good frames, flag bad ones
// S_BREAK | after a framing error; wait for the line to return high
module uart_rx_fifo #(
    parameter int CLKS_PER_BAUD = 104,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          rx_i,
    input  logic                          rd_en_i,
    input  logic                          err_clr_i,
    output logic [DATA_BITS-1:0]          rd_data_o,
    output logic                          rd_valid_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          frame_err_o,
    output logic                          parity_err_o,
    output logic                          overrun_o
);
    localparam int CW   = $clog2(CLKS_PER_BAUD);
    localparam int BW   = $clog2(DATA_BITS);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BAUD / 2 - 1);
    localparam logic [CW-1:0] BAUD_M1 = CW'(CLKS_PER_BAUD - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    logic [1:0] sync_q;
    logic [2:0] taps_q;
    logic       rxf;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync_q <= '1;
            taps_q <= '1;
        end else begin
            sync_q <= {sync_q[0], rx_i};
            taps_q <= {taps_q[1:0], sync_q[1]};
        end
    end

    assign rxf = (taps_q[0] & taps_q[1]) | (taps_q[0] & taps_q[2]) | (taps_q[1] & taps_q[2]);

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [BW-1:0]          bit_q;
    logic [1:0]             stop_q;
    logic [DATA_BITS-1:0]   shreg_q;
    logic                   par_ok_q;
    logic                   push_q;
    logic [DATA_BITS-1:0]   push_data_q;
    logic                   frame_err_q;
    logic                   parity_err_q;
    logic                   baud_done;
    logic                   par_exp;

    assign baud_done = (cnt_q == BAUD_M1);
    assign par_exp   = (^shreg_q) ^ (PARITY == 2);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            stop_q       <= '0;
            shreg_q      <= '0;
            par_ok_q     <= 1'b1;
            push_q       <= 1'b0;
            push_data_q  <= '0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            push_q <= 1'b0;
            cnt_q  <= cnt_q + CW'(1);
            // err_clr first so a same-cycle set below takes priority
            if (err_clr_i) begin
                frame_err_q  <= 1'b0;
                parity_err_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (rxf) begin
                        cnt_q <= '0;
                    end else if (cnt_q == HALF_M1) begin
                        state_q  <= S_START;
                        cnt_q    <= '0;
                        par_ok_q <= 1'b1;
                    end
                end
                S_START: begin
                    if (cnt_q == '0 && rxf) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else if (baud_done) begin
                        shreg_q <= {rxf, shreg_q[DATA_BITS-1:1]};
                        bit_q   <= BW'(1);
                        cnt_q   <= '0;
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (baud_done) begin
                        shreg_q <= {rxf, shreg_q[DATA_BITS-1:1]};
                        bit_q   <= bit_q + BW'(1);
                        cnt_q   <= '0;
                        stop_q  <= '0;
                        if (bit_q == BW'(DATA_BITS - 1))
                            state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    if (baud_done) begin
                        par_ok_q <= (rxf == par_exp);
                        cnt_q    <= '0;
                        state_q  <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (baud_done) begin
                        cnt_q <= '0;
                        if (!rxf) begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_BREAK;
                        end else if (stop_q == 2'(STOP_BITS - 1)) begin
                            if (par_ok_q) begin
                                push_q      <= 1'b1;
                                push_data_q <= shreg_q;
                            end else begin
                                parity_err_q <= 1'b1;
                            end
                            state_q <= S_IDLE;
                        end else begin
                            stop_q <= stop_q + 2'd1;
                        end
                    end
                end
                S_BREAK: begin
                    cnt_q <= '0;
                    if (rxf) state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0]      count_q, count_d;
    logic                 overrun_q;
    logic                 pop, full, do_push;

    assign pop     = rd_en_i && (count_q != '0);
    assign full    = (count_q == CNTW'(FIFO_DEPTH));
    assign do_push = push_q && (!full || pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !pop)
            count_d = count_q + CNTW'(1);
        else if (!do_push && pop)
            count_d = count_q - CNTW'(1);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_q;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            if (err_clr_i) overrun_q <= 1'b0;
            if (push_q && full && !pop) overrun_q <= 1'b1;
        end
    end

    assign rd_data_o    = mem_q[rd_ptr_q];
    assign rd_valid_o   = (count_q != '0);
    assign fifo_count_o = count_q;
    assign frame_err_o  = frame_err_q;
    assign parity_err_o = parity_err_q;
    assign overrun_o    = overrun_q;
endmodule
